// File: rtl/dsm_decim.sv
// dsm_decim: third-order CIC decimator recovering signed PCM from a 1-bit
// delta-sigma bitstream.
//
// Optional feature macro: DSM_DECIM_WARMUP_MASK_EN
//   When defined, the first three decoded frames after reset are swallowed
//   (out stays 0, no out_valid) while the filter settles.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   bit_en     bitstream strobe; bit_in is sampled when high
//   bit_in     modulator bit, 1 -> +1, 0 -> -1
//   out        decoded signed sample, held between updates
//   out_valid  one-cycle pulse marking a new out value
module dsm_decim #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DECIM      = 64,
  parameter int unsigned LOG2D      = $clog2(DECIM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bit_en,
  input  logic                         bit_in,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_valid
);

  localparam int unsigned W     = 2 + 3 * LOG2D;
  localparam int unsigned Shift = 3 * LOG2D - (DATA_WIDTH - 1);

  // Clamp limits expressed at filter width so the comparison is exact.
  localparam logic signed [W-1:0] YMax = {{(W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [W-1:0] YMin = {{(W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic signed [W-1:0] x;
  logic signed [W-1:0] i1_q, i2_q, i3_q;
  logic signed [W-1:0] d1_q, d2_q, d3_q;
  logic signed [W-1:0] c1, c2, c3, c3_q;
  logic signed [W-1:0] y_shift;
  logic signed [DATA_WIDTH-1:0] y_sat;
  logic [LOG2D-1:0]    cnt_q;
  logic                frame_last;
  logic                frame_done_q;
  logic                comb_valid_q;
  logic                emit;

  assign x          = bit_in ? W'(1) : {W{1'b1}};
  assign frame_last = bit_en && (cnt_q == LOG2D'(DECIM - 1));

  // Combs run at the decimated rate on the registered i3. Wrap-around in the
  // integrators cancels here, so no saturation is needed inside the filter.
  always_comb begin
    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
  end

  always_comb begin
    y_shift = c3_q >>> Shift;
    if (y_shift > YMax) begin
      y_sat = YMax[DATA_WIDTH-1:0];
    end else if (y_shift < YMin) begin
      y_sat = YMin[DATA_WIDTH-1:0];
    end else begin
      y_sat = y_shift[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      c3_q         <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      comb_valid_q <= 1'b0;
      out          <= '0;
      out_valid    <= 1'b0;
    end else begin
      // Pipelined cascade: every stage adds the pre-edge value of its source.
      if (bit_en) begin
        i1_q  <= i1_q + x;
        i2_q  <= i2_q + i1_q;
        i3_q  <= i3_q + i2_q;
        cnt_q <= cnt_q + LOG2D'(1);
      end
      frame_done_q <= frame_last;
      comb_valid_q <= frame_done_q;
      if (frame_done_q) begin
        d1_q <= i3_q;
        d2_q <= c1;
        d3_q <= c2;
        c3_q <= c3;
      end
      out_valid <= comb_valid_q && emit;
      if (comb_valid_q && emit) begin
        out <= y_sat;
      end
    end
  end

`ifdef DSM_DECIM_WARMUP_MASK_EN
  typedef enum logic [0:0] {StWarm, StRun} state_e;

  state_e     state_q, state_d;
  logic [1:0] warm_q, warm_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWarm;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // Counts decoded frames while warming; the third one hands over to RUN so
  // the fourth frame is the first to reach the output.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    emit    = 1'b0;
    unique case (state_q)
      StWarm: begin
        if (comb_valid_q) begin
          if (warm_q == 2'd2) begin
            state_d = StRun;
          end else begin
            warm_d = warm_q + 2'd1;
          end
        end
      end
      StRun: begin
        emit = 1'b1;
      end
      default: begin
        state_d = StWarm;
      end
    endcase
  end
`else
  assign emit = 1'b1;
`endif

endmodule

// File: tb/tb_dsm_decim.sv
// tb_dsm_decim: self-checking bench for dsm_decim. A wide-integer CIC model
// fed by the driver pushes expected samples (value and due clock edge) into a
// queue; the monitor pops and compares them on every out_valid.
module tb_dsm_decim;

  localparam int DW    = 16;
  localparam int DECIM = 64;
`ifdef DSM_DECIM_WARMUP_MASK_EN
  localparam int Masked = 3;
`else
  localparam int Masked = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 bit_en;
  logic                 bit_in;
  logic signed [DW-1:0] out;
  logic                 out_valid;

  dsm_decim #(
    .DATA_WIDTH(DW),
    .DECIM     (DECIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_en   (bit_en),
    .bit_in   (bit_in),
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic signed [DW-1:0] val;
    int                   due;
  } exp_t;
  exp_t exp_q[$];

  // Wide model: no wrap, so the combs see the true integrator values.
  longint m1, m2, m3, md1, md2, md3;
  int     mcnt, mframes;

  task automatic model_clear();
    m1 = 0; m2 = 0; m3 = 0; md1 = 0; md2 = 0; md3 = 0;
    mcnt = 0; mframes = 0;
    exp_q.delete();
  endtask

  task automatic model_bit(input logic b);
    longint c1, c2, c3, y;
    exp_t   e;
    m3 = m3 + m2;
    m2 = m2 + m1;
    m1 = m1 + (b ? 64'sd1 : -64'sd1);
    mcnt++;
    if (mcnt == DECIM) begin
      mcnt = 0;
      c1 = m3 - md1;
      c2 = c1 - md2;
      c3 = c2 - md3;
      md1 = m3; md2 = c1; md3 = c2;
      y = c3 >>> 3;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      mframes++;
      if (mframes > Masked) begin
        e.val = DW'(y);
        e.due = cyc + 3; // sampling edge is cyc+1, output two edges later
        exp_q.push_back(e);
      end
    end
  endtask

  // Drive one clock's worth of inputs; called just after a posedge.
  task automatic step(input logic en, input logic b);
    bit_en = en;
    bit_in = b;
    if (en) model_bit(b);
    @(posedge clk);
    #1;
  endtask

  int rst_cyc;
  int first_valid;
  int valid_cnt;
  logic signed [DW-1:0] held;

  task automatic do_reset();
    rst    = 1'b1;
    bit_en = 1'b1; // rst must win over a simultaneous strobe
    bit_in = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst         = 1'b0;
    rst_cyc     = cyc;
    first_valid = -1;
    valid_cnt   = 0;
    chk("reset_out", out, 0);
    chk("reset_valid", out_valid, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = '0;
    end else if (out_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sample_value", out, e.val);
        chk("sample_edge", cyc, e.due);
      end
      held = out;
    end else begin
      chk("hold", out, held);
    end
  end

  typedef struct {
    logic [3:0]           pat;
    int                   plen;
    int                   div;
    int                   frames;
    logic signed [DW-1:0] settled;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{pat: 4'b1111, plen: 1, div: 1, frames: 6, settled: 16'sd32767};
    vecs[1] = '{pat: 4'b0000, plen: 1, div: 1, frames: 6, settled: -16'sd32768};
    vecs[2] = '{pat: 4'b0001, plen: 2, div: 1, frames: 6, settled: 16'sd0};
    vecs[3] = '{pat: 4'b0111, plen: 4, div: 1, frames: 6, settled: 16'sd16384};
    vecs[4] = '{pat: 4'b1111, plen: 1, div: 2, frames: 6, settled: 16'sd32767};
    vecs[5] = '{pat: 4'b0000, plen: 1, div: 3, frames: 5, settled: -16'sd32768};

    rst    = 1'b1;
    bit_en = 1'b0;
    bit_in = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("init_out", out, 0);
    chk("init_valid", out_valid, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int s = 0; s < vecs[v].frames * DECIM; s++) begin
        repeat (vecs[v].div - 1) step(1'b0, 1'($urandom));
        step(1'b1, vecs[v].pat[s % vecs[v].plen]);
      end
      repeat (4) step(1'b0, 1'b0);
      chk($sformatf("settled_v%0d", v), out, vecs[v].settled);
      chk($sformatf("frames_v%0d", v), valid_cnt, vecs[v].frames - Masked);
      chk($sformatf("drained_v%0d", v), exp_q.size(), 0);
    end

    // First-sample latency after reset release with a full-rate stream.
    do_reset();
    for (int s = 0; s < 5 * DECIM; s++) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    chk("first_latency", first_valid - rst_cyc, (Masked + 1) * DECIM + 2);

    // Reset 30 strobes into a frame: partial frame discarded, counter restarts.
    for (int s = 0; s < 30; s++) step(1'b1, 1'b0);
    do_reset();
    for (int s = 0; s < 5 * DECIM; s++) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    chk("midreset_latency", first_valid - rst_cyc, (Masked + 1) * DECIM + 2);
    chk("midreset_out", out, 32767);

    // Random bits with random gaps, including gaps inside frames.
    do_reset();
    for (int s = 0; s < 8 * DECIM; s++) begin
      if ($urandom_range(3) == 0) step(1'b0, 1'($urandom));
      step(1'b1, 1'($urandom));
    end
    repeat (4) step(1'b0, 1'b0);
    chk("random_frames", valid_cnt, 8 - Masked);
    chk("random_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
